// File: rtl/rr_arb_mux_pkg.sv
// Shared helpers for the round-robin arbitrated mux family.
package rr_arb_mux_pkg;

   // Channel-index width; never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Reset pointer sits on the last channel so channel 0 has first priority.
   localparam int unsigned RST_PTR_BACKOFF = 1;

   function automatic int unsigned rst_ptr(input int unsigned n);
      return n - RST_PTR_BACKOFF;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant logic: double-width masked priority encoder over req,
// scanning upward from last_grant+1 with explicit modulo wrap.
module rr_arbiter
   import rr_arb_mux_pkg::*;
#(
   parameter  int unsigned NUM_CH = 4,
   localparam int unsigned CH_W   = clog2_min1(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   last_grant,
   output logic [NUM_CH-1:0] grant,
   output logic [CH_W-1:0]   grant_idx,
   output logic              grant_valid
);

   logic [2*NUM_CH-1:0] req_dbl;

   assign req_dbl = {req, req};

   // Only positions strictly above last_grant and within one lap may win.
   always_comb begin
      grant_idx   = '0;
      grant_valid = 1'b0;
      for (int unsigned k = 0; k < 2 * NUM_CH; k++) begin
         if (!grant_valid && req_dbl[k] &&
             (k > int'(last_grant)) && (k <= int'(last_grant) + NUM_CH)) begin
            grant_valid = 1'b1;
            grant_idx   = (k >= NUM_CH) ? CH_W'(k - NUM_CH) : CH_W'(k);
         end
      end
   end

   always_comb begin
      grant = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (grant_valid && (grant_idx == CH_W'(i))) grant[i] = 1'b1;
      end
   end

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin N:1 valid/ready mux with a single registered output stage.
// Optional packet lock (in_last/out_last) enabled by RR_ARB_MUX_PKT_LOCK_EN.
module rr_arb_mux
   import rr_arb_mux_pkg::*;
#(
   parameter  int unsigned WIDTH  = 8,
   parameter  int unsigned NUM_CH = 4,
   localparam int unsigned CH_W   = clog2_min1(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       in_valid,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
`ifdef RR_ARB_MUX_PKT_LOCK_EN
   input  logic [NUM_CH-1:0]       in_last,
`endif
   output logic [NUM_CH-1:0]       in_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [CH_W-1:0]         out_ch,
`ifdef RR_ARB_MUX_PKT_LOCK_EN
   output logic                    out_last,
`endif
   input  logic                    out_ready
);

   localparam int unsigned RST_PTR = rst_ptr(NUM_CH);

   logic              load;
   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] grant;
   logic [CH_W-1:0]   grant_idx;
   logic              grant_valid;
   logic [CH_W-1:0]   last_grant;
   logic [WIDTH-1:0]  data_mux;

   assign load     = !out_valid || out_ready;
   assign in_ready = grant & {NUM_CH{load}};

`ifdef RR_ARB_MUX_PKT_LOCK_EN
   logic lock;
   logic last_mux;

   // While locked only the channel that opened the packet may request.
   always_comb begin
      req = in_valid;
      if (lock) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            req[i] = in_valid[i] && (last_grant == CH_W'(i));
         end
      end
   end

   assign last_mux = |(grant & in_last);
`else
   assign req = in_valid;
`endif

   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .req         (req),
      .last_grant  (last_grant),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   always_comb begin
      data_mux = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (grant[i]) data_mux = in_data[i*WIDTH +: WIDTH];
      end
   end

   // Output stage and pointer; pointer moves only on a transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_ch     <= '0;
         last_grant <= CH_W'(RST_PTR);
      end else if (load) begin
         out_valid <= grant_valid;
         if (grant_valid) begin
            out_data   <= data_mux;
            out_ch     <= grant_idx;
            last_grant <= grant_idx;
         end
      end
   end

`ifdef RR_ARB_MUX_PKT_LOCK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_last <= 1'b0;
         lock     <= 1'b0;
      end else if (load && grant_valid) begin
         out_last <= last_mux;
         lock     <= !last_mux;
      end
   end
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: directed test-plan sequences plus random traffic.
module tb_rr_arb_mux;

   localparam int unsigned W  = 8;
   localparam int unsigned NC = 4;
   localparam int unsigned CW = 2;

   logic          clk;
   logic          rst_n;
   logic [NC-1:0] in_valid;
   logic [NC*W-1:0] in_data;
   logic [NC-1:0] in_ready;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic [CW-1:0] out_ch;
   logic          out_ready;
   logic [NC-1:0] in_last;
   logic          out_last;

   rr_arb_mux #(
      .WIDTH  (W),
      .NUM_CH (NC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
`ifdef RR_ARB_MUX_PKT_LOCK_EN
      .in_last   (in_last),
`endif
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
`ifdef RR_ARB_MUX_PKT_LOCK_EN
      .out_last  (out_last),
`endif
      .out_ready (out_ready)
   );

`ifndef RR_ARB_MUX_PKT_LOCK_EN
   assign out_last = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] d;
      int           ch;
      bit           last;
   } beat_t;

   beat_t         sb[$];
   int            log_ch[$];
   bit            log_last[$];
   int            exp_q[$];
   int            m_ptr;
   bit            m_full;
   bit            m_lock;
   bit            m_load;
   int            m_win;
   logic [NC-1:0] m_rdy;
   logic [NC-1:0] acc;
   beat_t         m_beat;
   int            n_chk;
   int            n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_seq(input string nm);
      chk({nm, "_len"}, 32'(log_ch.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < log_ch.size(); i++)
         chk(nm, 32'(log_ch[i]), 32'(exp_q[i]));
   endtask

   task automatic model_reset();
      sb.delete();
      m_full = 1'b0;
      m_lock = 1'b0;
      m_ptr  = NC - 1;
      acc    = '0;
   endtask

   // Monitor: output must match the oldest accepted beat; pop on drain.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
         if (out_valid && sb.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(sb[0].d));
            chk("out_ch", 32'(out_ch), 32'(sb[0].ch));
`ifdef RR_ARB_MUX_PKT_LOCK_EN
            chk("out_last", 32'(out_last), 32'(sb[0].last));
`endif
            if (out_ready) begin
               log_ch.push_back(int'(out_ch));
               log_last.push_back(out_last);
               void'(sb.pop_front());
            end
         end
      end
   end

   // Reference model: round-robin scan from pointer+1, one-deep output buffer.
   always @(negedge clk) begin
      #1;
      if (rst_n) begin
         m_load = !m_full || out_ready;
         m_win  = -1;
         for (int j = 1; j <= int'(NC); j++) begin
            int c;
            c = (m_ptr + j) % int'(NC);
            if (m_win < 0 && in_valid[c] && (!m_lock || c == m_ptr)) m_win = c;
         end
         m_rdy = '0;
         if (m_load && m_win >= 0) m_rdy[m_win] = 1'b1;
         chk("in_ready", 32'(in_ready), 32'(m_rdy));
         acc = in_valid & m_rdy;
         if (m_load) m_full = (m_win >= 0);
         if (m_load && m_win >= 0) begin
            m_beat.d    = in_data[m_win*W +: W];
            m_beat.ch   = m_win;
            m_beat.last = in_last[m_win];
            sb.push_back(m_beat);
            m_ptr = m_win;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
            m_lock = !m_beat.last;
`endif
         end
      end
   end

   initial begin
      n_chk = 0;
      n_fail = 0;
      in_valid = '0;
      in_data = '0;
      in_last = '1;
      out_ready = 1'b1;
      model_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_ch", 32'(out_ch), 32'd0);
      cyc(2);
      rst_n = 1'b1;

      // All four channels valid: grants 0,1,2,3,0 at one per cycle.
      log_ch.delete();
      in_valid = 4'hF;
      in_data = {8'h13, 8'h12, 8'h11, 8'h10};
      #1 chk("first_ready", 32'(in_ready), 32'h1);
      cyc(1);
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("lat_data", 32'(out_data), 32'h10);
      cyc(4);
      in_valid = '0;
      cyc(2);
      exp_q = {0, 1, 2, 3, 0};
      chk_seq("rr_seq");

      // Backpressure hold on ch2.
      in_valid = 4'b0100;
      in_data[2*W +: W] = 8'hA5;
      cyc(1);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_data", 32'(out_data), 32'hA5);
         chk("hold_ch", 32'(out_ch), 32'd2);
         chk("hold_ready", 32'(in_ready), 32'd0);
         cyc(1);
      end
      out_ready = 1'b1;
      in_valid = '0;
      cyc(1);
      chk("drain_valid", 32'(out_valid), 32'd0);
      cyc(1);

      // Wrap and skip: ch3, then ch1/ch3 alternate.
      log_ch.delete();
      in_valid = 4'b1000;
      cyc(1);
      in_valid = 4'b1010;
      cyc(3);
      in_valid = '0;
      cyc(2);
      exp_q = {3, 1, 3, 1};
      chk_seq("wrap_seq");

      // Idle cycles do not rotate priority.
      log_ch.delete();
      in_valid = 4'b0010;
      cyc(1);
      in_valid = '0;
      cyc(5);
      in_valid = 4'b0101;
      cyc(1);
      in_valid = '0;
      cyc(2);
      exp_q = {1, 2};
      chk_seq("idle_seq");

      // Asynchronous reset while a beat is pending.
      in_valid = 4'hF;
      cyc(2);
      #2;
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_ch", 32'(out_ch), 32'd0);
      model_reset();
      in_valid = '0;
      cyc(1);
      rst_n = 1'b1;
      log_ch.delete();
      in_valid = 4'hF;
      cyc(1);
      in_valid = '0;
      cyc(2);
      exp_q = {0};
      chk_seq("post_rst_seq");

`ifdef RR_ARB_MUX_PKT_LOCK_EN
      // ch1 three-beat packet while ch0 and ch2 also request.
      log_ch.delete();
      log_last.delete();
      in_valid = 4'b0111;
      in_last = 4'b0101;
      in_data = {8'h03, 8'h02, 8'h21, 8'h00};
      cyc(1);
      in_data[W +: W] = 8'h22;
      cyc(1);
      in_data[W +: W] = 8'h23;
      in_last[1] = 1'b1;
      cyc(1);
      in_valid[1] = 1'b0;
      cyc(1);
      in_valid[2] = 1'b0;
      cyc(1);
      in_valid = '0;
      cyc(2);
      exp_q = {1, 1, 1, 2, 0};
      chk_seq("lock_seq");
      for (int i = 0; i < 3 && i < log_last.size(); i++)
         chk("lock_last", 32'(log_last[i]), (i == 2) ? 32'd1 : 32'd0);
`endif

      // Random traffic; a pending request holds until accepted.
      in_valid = '0;
      cyc(1);
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < int'(NC); i++) begin
            if (!(in_valid[i] && !acc[i])) begin
               in_valid[i] = 1'($urandom_range(0, 1));
               in_data[i*W +: W] = W'($urandom);
               in_last[i] = ($urandom_range(0, 2) != 0);
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         cyc(1);
      end

      in_valid = '0;
      out_ready = 1'b1;
      cyc(4);
      chk("final_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
